dbus_sram_responder: RTL and testbench
======================================

// Module: dbus_sram_responder
// PURPOSE
//  Slave end of the data-bus handshake driven by the pipeline memory stage.
//  Accepts one dbus_req_t at a time and returns dbus_resp_t after a fixed
//  latency. Backed by a 64-bit-word SRAM array with byte-strobe writes.
//  Used as the data memory in simulation and in FPGA builds without a cache.
// PARAMETERS
//  DEPTH_WORDS  1024          number of 64-bit words; power of two, >= 2
//  LATENCY      2             cycles from request acceptance to data_ok; >= 1
//  BASE_ADDR    64'h8000_0000 byte address of word 0; DEPTH_WORDS*8 aligned
// PORTS
//  clk      in   1           clock; all state changes on the rising edge
//  reset    in   1           asynchronous, active-high reset
//  dreq     in   dbus_req_t  valid, addr[63:0], size, strobe[7:0], data[63:0]
//  dresp    out  dbus_resp_t addr_ok, data_ok, data[63:0]
//  busy     out  1           high in WAIT and RESP
//  oob_err  out  1           sticky; set on any out-of-range access
// BEHAVIOUR
//  Reset values: state=IDLE, cnt=0, dresp.addr_ok=0, dresp.data_ok=0,
//   dresp.data=0, busy=0, oob_err=0. SRAM contents are NOT reset.
//  Word index = (addr - BASE_ADDR) >> 3; addr[2:0] is ignored by the array.
//   The requester shifts by addr[2:0]. In range: BASE_ADDR <= addr <
//   BASE_ADDR + 8*DEPTH_WORDS.
//  FSM (registered):
//   IDLE: if dreq.valid, latch addr/strobe/data, cnt<=LATENCY-1.
//         Next state is RESP if LATENCY==1, else WAIT.
//   WAIT: if !dreq.valid, abort to IDLE (no write, no response).
//         Else if cnt==1, go to RESP. Otherwise cnt<=cnt-1.
//   RESP: addr_ok=data_ok=1 for exactly this one cycle. Next state IDLE.
//  Latency: first cycle valid is high in IDLE = cycle 0; data_ok is high in
//   cycle LATENCY. Back-to-back requests: a request valid in the RESP cycle
//   is not accepted. The next acceptance is in IDLE, so throughput is
//   1 request per LATENCY+1 cycles.
//  Read: dresp.data = mem[index] latched on entry to RESP, held until the
//   next RESP. For stores (strobe!=0) data returns the pre-write word.
//   Out-of-range reads return 64'h0.
//  Write: on the WAIT/IDLE->RESP edge, for each i with latched strobe[i]=1,
//   mem[index][8i+7:8i] <= latched data[8i+7:8i]. The write commits exactly
//   once. size is not used for writes; strobe is authoritative.
//  Out-of-range: writes are dropped, the response still completes with normal
//   timing, and oob_err<=1 at RESP. oob_err clears only on reset.
//  Requester contract: addr/strobe/data stay stable while valid until data_ok.
//   The responder uses only the values latched in IDLE.
//  Reset mid-operation (WAIT or RESP): return to IDLE immediately. A pending
//   write whose RESP edge has not occurred is discarded. data_ok drops
//   asynchronously.
//  Counter cnt is $clog2(LATENCY+1) bits wide and never wraps (reloaded in IDLE).
// TESTING
//  1. LATENCY=2, preload mem[0]=64'h1122334455667788; read addr 8000_0003.
//     -> data_ok high exactly at cycle 2 for one cycle, data=64'h1122334455667788.
//  2. Store addr 8000_0008, strobe 8'b0000_1100, data 64'hAAAA_BBBB_CCCC_DDDD.
//     -> Later read of 8000_0008 returns bytes[3:2]=CCCC and other bytes unchanged.
//  3. Store then immediate load to the same word.
//     -> Store RESP returns the old word. The load is accepted one cycle after
//     RESP and returns the new word. Total 6 cycles for the pair.
//  4. Read addr 0000_0100 (below BASE).
//     -> data_ok at cycle 2, data=0, oob_err=1 and stays 1. No SRAM change.
//  5. Store issued, valid dropped in WAIT (cycle 1).
//     -> Returns to IDLE, no data_ok, memory unchanged.
//     Separately, reset asserted in WAIT -> data_ok=0 and busy=0 immediately.
//  6. LATENCY=1 and LATENCY=4 builds, 8 back-to-back loads.
//     -> data_ok spacing of 2 and 5 cycles respectively. Values match the
//     scoreboard.

Source files
------------

// File: rtl/dbus_sram_responder.sv
// Data-bus SRAM responder: slave side of the memory-stage handshake.
// Accepts one request at a time and answers after a fixed latency from a
// 64-bit-word array with byte-strobe writes.
//
//  state | meaning
//  IDLE  | ready; a valid request is latched and the latency count starts
//  WAIT  | counting down; dropping valid aborts the request without a write
//  RESP  | addr_ok/data_ok high for this one cycle; back to IDLE next

package dbus_pkg;
  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;
endpackage

module dbus_sram_responder
  import dbus_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2,
  parameter logic [63:0] BASE_ADDR   = 64'h8000_0000
) (
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output logic       busy,
  output logic       oob_err
);

  localparam int          IW       = $clog2(DEPTH_WORDS);
  localparam int          CW       = $clog2(LATENCY + 1);
  localparam logic [63:0] SPAN     = 64'(DEPTH_WORDS) << 3;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [63:0]   r_mem [DEPTH_WORDS];

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [IW-1:0] r_idx;
  logic          r_inr;
  logic [7:0]    r_strobe;
  logic [63:0]   r_data;
  logic [63:0]   r_rdata;
  logic          r_oob;

  logic [63:0]   w_off;
  logic          w_req_inr;
  logic [IW-1:0] w_req_idx;
  logic [IW-1:0] w_sel_idx;
  logic          w_sel_inr;
  logic [7:0]    w_sel_strobe;
  logic [63:0]   w_sel_data;
  logic          w_enter_resp;
  logic          w_resp_v;
  logic          w_unused_size;

  // Offset from the base; an address below the base wraps to a huge offset,
  // so a single unsigned compare covers both ends of the window.
  assign w_off     = dreq.addr - BASE_ADDR;
  assign w_req_inr = (w_off < SPAN);
  assign w_req_idx = w_off[3 +: IW];

  // Size is carried on the bus but strobe alone decides which bytes change.
  assign w_unused_size = ^dreq.size;

  // With LATENCY==1 the RESP edge is the accept edge, so the live request
  // is used instead of the (not yet loaded) latched copy.
  assign w_sel_idx    = (r_state == IDLE) ? w_req_idx   : r_idx;
  assign w_sel_inr    = (r_state == IDLE) ? w_req_inr   : r_inr;
  assign w_sel_strobe = (r_state == IDLE) ? dreq.strobe : r_strobe;
  assign w_sel_data   = (r_state == IDLE) ? dreq.data   : r_data;

  assign w_enter_resp = dreq.valid &&
                        (((r_state == IDLE) && (LATENCY == 1)) ||
                         ((r_state == WAIT) && (r_cnt == CNT_ONE)));

  assign w_resp_v = (r_state == RESP);
  assign dresp    = '{addr_ok: w_resp_v, data_ok: w_resp_v, data: r_rdata};
  assign busy     = (r_state == WAIT) || (r_state == RESP);
  assign oob_err  = r_oob;

  // Handshake FSM, request latch, read-data capture and sticky range error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_inr    <= 1'b0;
      r_strobe <= '0;
      r_data   <= '0;
      r_rdata  <= '0;
      r_oob    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (dreq.valid) begin
            r_idx    <= w_req_idx;
            r_inr    <= w_req_inr;
            r_strobe <= dreq.strobe;
            r_data   <= dreq.data;
            r_cnt    <= CNT_LOAD;
            r_state  <= (LATENCY == 1) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (!dreq.valid) begin
            r_state <= IDLE;
          end else if (r_cnt == CNT_ONE) begin
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase

      // Read returns the word as it was before this request's own write.
      if (w_enter_resp) begin
        r_rdata <= w_sel_inr ? r_mem[w_sel_idx] : 64'h0;
        if (!w_sel_inr) begin
          r_oob <= 1'b1;
        end
      end
    end
  end

  // Byte-strobed array write, committed once on the edge into RESP.
  always_ff @(posedge clk) begin
    if (w_enter_resp && w_sel_inr) begin
      for (int i = 0; i < 8; i++) begin
        if (w_sel_strobe[i]) begin
          r_mem[w_sel_idx][8*i +: 8] <= w_sel_data[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Bench for dbus_sram_responder: three builds (LATENCY 2, 1, 4) checked
// against a word-array reference model with directed and random traffic.
module tb_dbus_sram_responder;
  import dbus_pkg::*;

  localparam int          DEPTH = 64;
  localparam logic [63:0] BASE  = 64'h8000_0000;

  logic       clk = 1'b0;
  logic       reset;
  dbus_req_t  r_req  [3];
  dbus_resp_t w_resp [3];
  logic       w_busy [3];
  logic       w_oob  [3];

  int          lat_of [3] = '{2, 1, 4};
  logic [63:0] model     [3][DEPTH];
  bit          model_vld [3][DEPTH];
  bit          model_oob [3];
  bit          last_resp [3];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dbus_sram_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2), .BASE_ADDR(BASE)) u_lat2 (
    .clk(clk), .reset(reset), .dreq(r_req[0]), .dresp(w_resp[0]),
    .busy(w_busy[0]), .oob_err(w_oob[0]));
  dbus_sram_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1), .BASE_ADDR(BASE)) u_lat1 (
    .clk(clk), .reset(reset), .dreq(r_req[1]), .dresp(w_resp[1]),
    .busy(w_busy[1]), .oob_err(w_oob[1]));
  dbus_sram_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(4), .BASE_ADDR(BASE)) u_lat4 (
    .clk(clk), .reset(reset), .dreq(r_req[2]), .dresp(w_resp[2]),
    .busy(w_busy[2]), .oob_err(w_oob[2]));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One request; expects data_ok after LATENCY cycles from IDLE, or one
  // extra cycle when issued during the previous RESP.
  task automatic txn(input int k, input logic [63:0] addr, input logic [7:0] strb,
                     input logic [63:0] data, input string tag);
    logic [63:0] off;
    bit          inr;
    int          idx;
    int          n;
    int          exp_n;
    bit          got;
    logic [63:0] exp_d;
    off   = addr - BASE;
    inr   = (off < 64'(DEPTH * 8));
    idx   = inr ? int'(off >> 3) : 0;
    exp_n = lat_of[k] + (last_resp[k] ? 1 : 0);
    exp_d = inr ? model[k][idx] : 64'h0;
    r_req[k] = '{1'b1, addr, 3'd3, strb, data};
    n = 0;
    got = 0;
    while (n < 30 && !got) begin
      @(posedge clk); #1;
      n++;
      if (w_resp[k].data_ok === 1'b1) got = 1;
    end
    chk({tag, "_lat"}, 64'(n), 64'(exp_n));
    chk({tag, "_addr_ok"}, 64'(w_resp[k].addr_ok), 64'd1);
    chk({tag, "_busy"}, 64'(w_busy[k]), 64'd1);
    if (!inr || model_vld[k][idx]) chk({tag, "_data"}, w_resp[k].data, exp_d);
    if (inr) begin
      for (int b = 0; b < 8; b++)
        if (strb[b]) model[k][idx][8*b +: 8] = data[8*b +: 8];
      if (strb == 8'hFF) model_vld[k][idx] = 1;
    end else begin
      model_oob[k] = 1;
    end
    chk({tag, "_oob"}, 64'(w_oob[k]), 64'(model_oob[k]));
    last_resp[k] = 1;
  endtask

  task automatic idle(input int k);
    r_req[k].valid = 1'b0;
    @(posedge clk); #1;
    chk("idle_data_ok", 64'(w_resp[k].data_ok), 64'd0);
    chk("idle_busy", 64'(w_busy[k]), 64'd0);
    last_resp[k] = 0;
  endtask

  // Store that is withdrawn after one cycle in WAIT.
  task automatic abort_store(input int k, input logic [63:0] addr, input logic [63:0] data);
    r_req[k] = '{1'b1, addr, 3'd3, 8'hFF, data};
    @(posedge clk); #1;
    chk("abort_wait_busy", 64'(w_busy[k]), 64'd1);
    r_req[k].valid = 1'b0;
    for (int c = 0; c < lat_of[k] + 2; c++) begin
      @(posedge clk); #1;
      chk("abort_no_data_ok", 64'(w_resp[k].data_ok), 64'd0);
    end
    chk("abort_busy_clear", 64'(w_busy[k]), 64'd0);
  endtask

  function automatic logic [63:0] rand_addr(input bit allow_oob);
    logic [63:0] a;
    if (allow_oob && $urandom_range(0, 9) == 0) begin
      if ($urandom_range(0, 1) == 1) a = BASE - 64'($urandom_range(1, 800));
      else a = BASE + 64'(DEPTH * 8) + 64'($urandom_range(0, 800));
    end else begin
      a = BASE + (64'($urandom_range(0, DEPTH - 1)) << 3) + 64'($urandom_range(0, 7));
    end
    return a;
  endfunction

  function automatic logic [63:0] rand64();
    return {32'($urandom), 32'($urandom)};
  endfunction

  initial begin
    for (int k = 0; k < 3; k++) begin
      r_req[k] = '0;
      model_oob[k] = 0;
      last_resp[k] = 0;
      for (int w = 0; w < DEPTH; w++) begin
        model[k][w] = 64'h0;
        model_vld[k][w] = 0;
      end
    end
    reset = 1'b1;
    #2;
    for (int k = 0; k < 3; k++) begin
      chk("rst_addr_ok", 64'(w_resp[k].addr_ok), 64'd0);
      chk("rst_data_ok", 64'(w_resp[k].data_ok), 64'd0);
      chk("rst_data", w_resp[k].data, 64'h0);
      chk("rst_busy", 64'(w_busy[k]), 64'd0);
      chk("rst_oob", 64'(w_oob[k]), 64'd0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Fill every word of every build with back-to-back full stores.
    for (int k = 0; k < 3; k++) begin
      for (int w = 0; w < DEPTH; w++)
        txn(k, BASE + 64'(w * 8), 8'hFF, rand64(), "init");
      idle(k);
    end

    // Directed: preload and misaligned read, partial store, store->load pair.
    txn(0, BASE, 8'hFF, 64'h1122334455667788, "t1_store");
    idle(0);
    txn(0, 64'h8000_0003, 8'h00, 64'h0, "t1_read");
    idle(0);
    txn(0, 64'h8000_0008, 8'hFF, 64'h0102030405060708, "t2_pre");
    idle(0);
    txn(0, 64'h8000_0008, 8'b0000_1100, 64'hAAAA_BBBB_CCCC_DDDD, "t2_store");
    idle(0);
    txn(0, 64'h8000_0008, 8'h00, 64'h0, "t2_read");
    chk("t2_value", w_resp[0].data, 64'h0102030401020708 & 64'hFFFF_FFFF_0000_FFFF | 64'h0000_0000_CCCC_0000);
    idle(0);
    txn(0, 64'h8000_0010, 8'hF0, 64'h5555_6666_7777_8888, "t3_store");
    txn(0, 64'h8000_0010, 8'h00, 64'h0, "t3_load");
    idle(0);

    // Out of range below base, at the end of the window, and the last word.
    txn(0, 64'h0000_0100, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, "t4_below");
    idle(0);
    chk("t4_oob_sticky", 64'(w_oob[0]), 64'd1);
    txn(2, BASE + 64'(DEPTH * 8) - 64'd1, 8'h00, 64'h0, "edge_last");
    chk("edge_last_oob", 64'(w_oob[2]), 64'd0);
    txn(2, BASE + 64'(DEPTH * 8), 8'hFF, 64'h0, "edge_end");
    idle(2);
    txn(2, BASE - 64'd1, 8'h00, 64'h0, "edge_below");
    idle(2);

    // Aborted stores leave memory unchanged.
    abort_store(0, 64'h8000_0018, 64'hDEAD_BEEF_DEAD_BEEF);
    txn(0, 64'h8000_0018, 8'h00, 64'h0, "t5_read_l2");
    idle(0);
    abort_store(2, 64'h8000_0020, 64'hDEAD_BEEF_DEAD_BEEF);
    txn(2, 64'h8000_0020, 8'h00, 64'h0, "t5_read_l4");
    idle(2);

    // Per build: 8 back-to-back loads, then random mixed traffic.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 8; i++)
        txn(k, rand_addr(0), 8'h00, 64'h0, "b2b_load");
      idle(k);
      for (int i = 0; i < 40; i++) begin
        txn(k, rand_addr(1), ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00,
            rand64(), "rand");
        if ($urandom_range(0, 3) == 0) idle(k);
      end
      idle(k);
    end

    // Reset while a store sits in WAIT: outputs drop at once, write is lost.
    r_req[0] = '{1'b1, 64'h8000_0028, 3'd3, 8'hFF, 64'hCAFE_CAFE_CAFE_CAFE};
    @(posedge clk); #1;
    chk("rst_mid_busy_pre", 64'(w_busy[0]), 64'd1);
    reset = 1'b1;
    #1;
    chk("rst_mid_data_ok", 64'(w_resp[0].data_ok), 64'd0);
    chk("rst_mid_busy", 64'(w_busy[0]), 64'd0);
    for (int k = 0; k < 3; k++) chk("rst_mid_oob", 64'(w_oob[k]), 64'd0);
    r_req[0].valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      model_oob[k] = 0;
      last_resp[k] = 0;
    end
    @(posedge clk); #1;
    txn(0, 64'h8000_0028, 8'h00, 64'h0, "rst_retained");
    txn(1, 64'h8000_0000, 8'h00, 64'h0, "rst_retained_l1");
    idle(0);
    idle(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
